// File: rtl/prog_loader.sv
// Boot-image loader: validates an "ASRM" header, copies the payload into program
// memory, verifies an 8-bit additive checksum and only then releases the CPU.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  cpu_reset_n,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned MAX_LEN = DEPTH - 4;
    localparam int unsigned LEN_W   = 16;

    typedef enum logic [2:0] {
        S_MAGIC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              sum_q, sum_d;
    logic                    in_ready_q, in_ready_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              mem_data_q, mem_data_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    cpu_reset_n_q, cpu_reset_n_d;
    logic                    accept_c;

    // Expected header byte for a given magic index ("ASRM").
    function automatic logic [7:0] magic_byte(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = 8'h41;
            2'd1:    b = 8'h53;
            2'd2:    b = 8'h52;
            default: b = 8'h4D;
        endcase
        return b;
    endfunction

    assign accept_c = in_valid && in_ready_q;

    // Next-state, counters and registered-output targets.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            S_MAGIC: begin
                if (accept_c) begin
                    if (in_data == magic_byte(idx_q)) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ADDR_WIDTH'(idx_q);
                        mem_data_d = in_data;
                        if (idx_q == 2'd3) begin
                            idx_d   = 2'd0;
                            state_d = S_LEN_LO;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    len_d   = {len_q[15:8], in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    len_d = {in_data, len_q[7:0]};
                    cnt_d = '0;
                    // Oversize images would overrun memory, so they abort here.
                    if (32'({in_data, len_q[7:0]}) > MAX_LEN) begin
                        state_d = S_ERROR;
                    end else if ({in_data, len_q[7:0]} == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ADDR_WIDTH'(cnt_q + 16'd4);
                    mem_data_d = in_data;
                    sum_d      = sum_q + in_data;
                    cnt_d      = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept_c) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_MAGIC;
                    idx_d   = 2'd0;
                    len_d   = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            default: begin
                state_d = S_MAGIC;
            end
        endcase

        // Status outputs track the state being entered so they are registered.
        in_ready_d    = (state_d != S_DONE) && (state_d != S_ERROR);
        done_d        = (state_d == S_DONE);
        error_d       = (state_d == S_ERROR);
        cpu_reset_n_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_MAGIC;
            idx_q         <= 2'd0;
            len_q         <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            in_ready_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            in_ready_q    <= in_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cpu_reset_n_q <= cpu_reset_n_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_reset_n = cpu_reset_n_q;

endmodule
